// File: rtl/instr_fetch_pkg.sv
// Shared constants for the instruction fetch stage: FSM encodings and default widths
// (widths are shared with the external pc block).
package instr_fetch_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH  = 16;
  localparam int unsigned DEFAULT_INSTR_WIDTH = 16;
  localparam int unsigned DEFAULT_CNT_WIDTH   = 16;

  localparam logic [1:0] FETCH_IDLE     = 2'd0;
  localparam logic [1:0] FETCH_REQ      = 2'd1;
  localparam logic [1:0] FETCH_HOLD     = 2'd2;
  localparam logic [1:0] FETCH_REDIRECT = 2'd3;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory read bus: request/acknowledge with address and returned data.
// master = fetch stage, slave = instruction memory.
interface instr_fetch_if
  import instr_fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int unsigned INSTR_WIDTH = DEFAULT_INSTR_WIDTH
) ();

  logic                   imem_req;
  logic [ADDR_WIDTH-1:0]  imem_addr;
  logic                   imem_ack;
  logic [INSTR_WIDTH-1:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data
  );

endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: reads imem at the external PC, holds the word in ir for decode,
// strobes the PC increment/load controls and absorbs branch redirects from execute.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int unsigned INSTR_WIDTH = DEFAULT_INSTR_WIDTH,
  parameter int unsigned CNT_WIDTH   = DEFAULT_CNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic [ADDR_WIDTH-1:0]  pc_addr,
  output logic                   inc_pc,
  output logic                   load_pc,
  output logic [ADDR_WIDTH-1:0]  jump_target,
  instr_fetch_if.master          imem,
  output logic [INSTR_WIDTH-1:0] ir,
  output logic                   ir_valid,
  input  logic                   ir_ready,
  input  logic                   branch_req,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
  output logic [CNT_WIDTH-1:0]   fetch_count
);

  logic [1:0]             state_q, state_d;
  logic [INSTR_WIDTH-1:0] ir_q, ir_d;
  logic                   ir_valid_q, ir_valid_d;
  logic [CNT_WIDTH-1:0]   fetch_count_q, fetch_count_d;
  logic [ADDR_WIDTH-1:0]  target_q, target_d;
  logic                   pend_q, pend_d;

  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    ir_valid_d    = ir_valid_q;
    fetch_count_d = fetch_count_q;
    target_d      = target_q;
    pend_d        = pend_q;
    inc_pc        = 1'b0;
    load_pc       = 1'b0;

    // The newest redirect always wins, whatever state we are in.
    if (branch_req) begin
      target_d = branch_target;
      pend_d   = 1'b1;
    end

    unique case (state_q)
      FETCH_IDLE: begin
        if (branch_req) begin
          state_d = FETCH_REDIRECT;
        end else if (run) begin
          state_d = FETCH_REQ;
        end
      end

      FETCH_REQ: begin
        // The read is never abandoned; a redirect only decides what happens to the data.
        if (imem.imem_ack) begin
          if (branch_req || pend_q) begin
            state_d = FETCH_REDIRECT;
          end else begin
            ir_d       = imem.imem_data;
            ir_valid_d = 1'b1;
            inc_pc     = 1'b1;
            state_d    = FETCH_HOLD;
          end
        end
      end

      FETCH_HOLD: begin
        if (ir_ready) begin
          fetch_count_d = fetch_count_q + CNT_WIDTH'(1);
          ir_valid_d    = 1'b0;
          if (branch_req) begin
            state_d = FETCH_REDIRECT;
          end else begin
            state_d = run ? FETCH_REQ : FETCH_IDLE;
          end
        end else if (branch_req) begin
          ir_valid_d = 1'b0;
          state_d    = FETCH_REDIRECT;
        end
      end

      FETCH_REDIRECT: begin
        load_pc = 1'b1;
        // A fresh branch_req here keeps us in REDIRECT to load the newer target next cycle.
        if (!branch_req) begin
          pend_d  = 1'b0;
          state_d = run ? FETCH_REQ : FETCH_IDLE;
        end
      end

      default: state_d = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= FETCH_IDLE;
      ir_q          <= '0;
      ir_valid_q    <= 1'b0;
      fetch_count_q <= '0;
      target_q      <= '0;
      pend_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ir_q          <= ir_d;
      ir_valid_q    <= ir_valid_d;
      fetch_count_q <= fetch_count_d;
      target_q      <= target_d;
      pend_q        <= pend_d;
    end
  end

  assign imem.imem_req  = (state_q == FETCH_REQ);
  assign imem.imem_addr = pc_addr;
  assign jump_target    = target_q;
  assign ir             = ir_q;
  assign ir_valid       = ir_valid_q;
  assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: behavioural PC and instruction memory beside the DUT, a cycle table
// for the straight-line fetch/stall/branch flow, and hand-written redirect and reset sequences.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [15:0] pc_addr;
  logic        inc_pc;
  logic        load_pc;
  logic [15:0] jump_target;
  logic [15:0] ir;
  logic        ir_valid;
  logic        ir_ready;
  logic        branch_req;
  logic [15:0] branch_target;
  logic [15:0] fetch_count;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          mem_lat  = 0;
  int          mem_wait = 0;
  logic        mem_force = 1'b0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_ir;

  typedef struct {
    logic        run, rdy, br;
    logic [15:0] tgt;
    logic        req, inc, ld, vld;
    logic [15:0] addr, ir, fc, jt;
  } vec_t;

  vec_t vecs[18];

  always #5 clk = ~clk;

  instr_fetch_if #(.ADDR_WIDTH(16), .INSTR_WIDTH(16)) imem_bus ();

  instr_fetch #(
    .ADDR_WIDTH (16),
    .INSTR_WIDTH(16),
    .CNT_WIDTH  (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .pc_addr      (pc_addr),
    .inc_pc       (inc_pc),
    .load_pc      (load_pc),
    .jump_target  (jump_target),
    .imem         (imem_bus),
    .ir           (ir),
    .ir_valid     (ir_valid),
    .ir_ready     (ir_ready),
    .branch_req   (branch_req),
    .branch_target(branch_target),
    .fetch_count  (fetch_count)
  );

  // External PC: load has priority, otherwise increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_addr <= 16'h0000;
    else if (load_pc) pc_addr <= jump_target;
    else if (inc_pc) pc_addr <= pc_addr + 16'h0001;
  end

  // Instruction memory: acks after mem_lat waiting cycles with data = addr + 0x100.
  initial begin
    imem_bus.imem_ack  = 1'b0;
    imem_bus.imem_data = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      if (mem_force) begin
        imem_bus.imem_ack  = 1'b1;
        imem_bus.imem_data = 16'hdead;
      end else if (reset && imem_bus.imem_req) begin
        if (mem_wait >= mem_lat) begin
          imem_bus.imem_ack  = 1'b1;
          imem_bus.imem_data = imem_bus.imem_addr + 16'h0100;
        end else begin
          imem_bus.imem_ack = 1'b0;
        end
        mem_wait++;
      end else begin
        imem_bus.imem_ack = 1'b0;
        mem_wait = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every decode handshake pops the next expected instruction word.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      check("inc_load_exclusive", 32'(inc_pc & load_pc), 32'd0);
      if (ir_valid && ir_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL ir_pop: got 0x%0h, expected no delivery", ir);
        end else begin
          exp_ir = exp_q.pop_front();
          check("ir_pop", 32'(ir), 32'(exp_ir));
        end
      end
    end
  end

  task automatic drive(input logic r, input logic rd, input logic b, input logic [15:0] t);
    @(posedge clk);
    #1;
    run           = r;
    ir_ready      = rd;
    branch_req    = b;
    branch_target = t;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b0;
    run           = 1'b0;
    ir_ready      = 1'b0;
    branch_req    = 1'b0;
    branch_target = 16'h0000;

    vecs[0]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'd0, 16'h0000};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'd0, 16'h0000};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 16'h0100, 16'd0, 16'h0000};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0001, 16'h0100, 16'd1, 16'h0000};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0002, 16'h0101, 16'd1, 16'h0000};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0002, 16'h0101, 16'd2, 16'h0000};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0003, 16'h0102, 16'd2, 16'h0000};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0003, 16'h0102, 16'd3, 16'h0000};
    for (int i = 8; i <= 12; i++) begin
      vecs[i] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0004, 16'h0103, 16'd3, 16'h0000};
    end
    vecs[13] = '{1'b1, 1'b0, 1'b1, 16'h0040, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0004, 16'h0103, 16'd3, 16'h0000};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0004, 16'h0103, 16'd3, 16'h0040};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h0103, 16'd3, 16'h0040};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0041, 16'h0140, 16'd3, 16'h0040};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0041, 16'h0140, 16'd4, 16'h0040};

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_imem_req", 32'(imem_bus.imem_req), 32'd0);
    check("rst_inc_pc", 32'(inc_pc), 32'd0);
    check("rst_load_pc", 32'(load_pc), 32'd0);
    check("rst_jump_target", 32'(jump_target), 32'd0);
    check("rst_ir", 32'(ir), 32'd0);
    check("rst_ir_valid", 32'(ir_valid), 32'd0);
    check("rst_fetch_count", 32'(fetch_count), 32'd0);
    check("rst_imem_addr", 32'(imem_bus.imem_addr), 32'd0);
    reset = 1'b1;

    // Straight-line fetch, 5-cycle stall, branch to 0x40 from HOLD
    exp_q.push_back(16'h0100);
    exp_q.push_back(16'h0101);
    exp_q.push_back(16'h0102);
    exp_q.push_back(16'h0140);
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].run, vecs[i].rdy, vecs[i].br, vecs[i].tgt);
      @(negedge clk);
      check($sformatf("row%0d imem_req", i), 32'(imem_bus.imem_req), 32'(vecs[i].req));
      check($sformatf("row%0d inc_pc", i), 32'(inc_pc), 32'(vecs[i].inc));
      check($sformatf("row%0d load_pc", i), 32'(load_pc), 32'(vecs[i].ld));
      check($sformatf("row%0d ir_valid", i), 32'(ir_valid), 32'(vecs[i].vld));
      check($sformatf("row%0d imem_addr", i), 32'(imem_bus.imem_addr), 32'(vecs[i].addr));
      check($sformatf("row%0d ir", i), 32'(ir), 32'(vecs[i].ir));
      check($sformatf("row%0d fetch_count", i), 32'(fetch_count), 32'(vecs[i].fc));
      check($sformatf("row%0d jump_target", i), 32'(jump_target), 32'(vecs[i].jt));
    end

    // Branch to 0x80 while a 3-wait read is outstanding
    mem_lat = 3;
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    drive(1'b1, 1'b0, 1'b1, 16'h0080);
    @(negedge clk);
    check("a_req_held1", 32'(imem_bus.imem_req), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    check("a_req_held2", 32'(imem_bus.imem_req), 32'd1);
    check("a_addr_stable", 32'(imem_bus.imem_addr), 32'h0041);
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    check("a_req_held3", 32'(imem_bus.imem_req), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    check("a_ack_req", 32'(imem_bus.imem_req), 32'd1);
    check("a_ack_no_inc", 32'(inc_pc), 32'd0);
    check("a_ack_no_load", 32'(load_pc), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    check("a_load_pc", 32'(load_pc), 32'd1);
    check("a_jump_target", 32'(jump_target), 32'h0080);
    check("a_ir_discarded", 32'(ir), 32'h0140);
    check("a_ir_valid", 32'(ir_valid), 32'd0);
    exp_q.push_back(16'h0180);
    drive(1'b0, 1'b1, 1'b0, 16'h0000);
    @(negedge clk);
    check("a_refetch_addr", 32'(imem_bus.imem_addr), 32'h0080);
    check("a_refetch_req", 32'(imem_bus.imem_req), 32'd1);
    drive(1'b0, 1'b1, 1'b0, 16'h0000);
    drive(1'b0, 1'b1, 1'b0, 16'h0000);
    drive(1'b0, 1'b1, 1'b0, 16'h0000);
    @(negedge clk);
    check("a_refetch_inc", 32'(inc_pc), 32'd1);
    drive(1'b0, 1'b1, 1'b0, 16'h0000);
    @(negedge clk);
    check("a_hold_valid", 32'(ir_valid), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    check("a_idle_req", 32'(imem_bus.imem_req), 32'd0);
    check("a_fetch_count", 32'(fetch_count), 32'd5);

    // Back-to-back branches 0x10 then 0x20
    mem_lat = 0;
    drive(1'b1, 1'b0, 1'b1, 16'h0010);
    @(negedge clk);
    check("b_idle_no_load", 32'(load_pc), 32'd0);
    drive(1'b1, 1'b0, 1'b1, 16'h0020);
    @(negedge clk);
    check("b_load1", 32'(load_pc), 32'd1);
    check("b_jt1", 32'(jump_target), 32'h0010);
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    check("b_load2", 32'(load_pc), 32'd1);
    check("b_jt2", 32'(jump_target), 32'h0020);
    exp_q.push_back(16'h0120);
    drive(1'b0, 1'b1, 1'b0, 16'h0000);
    @(negedge clk);
    check("b_resume_addr", 32'(imem_bus.imem_addr), 32'h0020);
    check("b_resume_inc", 32'(inc_pc), 32'd1);
    drive(1'b0, 1'b1, 1'b0, 16'h0000);
    @(negedge clk);
    check("b_ir", 32'(ir), 32'h0120);
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    check("b_fetch_count", 32'(fetch_count), 32'd6);

    // Reset during REQ with a stray ack just after release
    mem_lat = 3;
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    check("c_req_before_reset", 32'(imem_bus.imem_req), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("c_rst_imem_req", 32'(imem_bus.imem_req), 32'd0);
    check("c_rst_inc_pc", 32'(inc_pc), 32'd0);
    check("c_rst_load_pc", 32'(load_pc), 32'd0);
    check("c_rst_jump_target", 32'(jump_target), 32'd0);
    check("c_rst_ir", 32'(ir), 32'd0);
    check("c_rst_ir_valid", 32'(ir_valid), 32'd0);
    check("c_rst_fetch_count", 32'(fetch_count), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    reset     = 1'b1;
    mem_force = 1'b1;
    @(negedge clk);
    mem_force = 1'b0;
    check("c_late_ack_no_inc", 32'(inc_pc), 32'd0);
    check("c_late_ack_no_req", 32'(imem_bus.imem_req), 32'd0);
    @(negedge clk);
    check("c_late_ack_ir", 32'(ir), 32'd0);
    check("c_late_ack_ir_valid", 32'(ir_valid), 32'd0);
    check("c_late_ack_idle", 32'(imem_bus.imem_req), 32'd0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage directly downstream of the scheduler program counter. Takes the current PC address, runs a request/acknowledge read against instruction memory, and latches the returned word into an instruction register that is handed to decode with a valid/ready handshake. Drives the PC's increment and load controls. Absorbs branch redirects from execute, including redirects that arrive while a memory read is outstanding.

## Interface
- ADDR_WIDTH, 16, instruction-memory address width; matches PC width.
- INSTR_WIDTH, 16, instruction word width.
- CNT_WIDTH, 16, fetch counter width.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  fetch enable from scheduler.
- pc_addr  in  ADDR_WIDTH  current PC value (PC AR output).
- inc_pc  out  1  PC increment strobe (PC incPC).
- load_pc  out  1  PC load strobe (PC loadFromI).
- jump_target  out  ADDR_WIDTH  PC load value (PC I input).
- imem_req  out  1  memory read request.
- imem_addr  out  ADDR_WIDTH  memory read address.
- imem_ack  in  1  read data valid this cycle.
- imem_data  in  INSTR_WIDTH  read data.
- ir  out  INSTR_WIDTH  instruction register.
- ir_valid  out  1  ir holds an unconsumed instruction.
- ir_ready  in  1  decode accepts ir this cycle.
- branch_req  in  1  redirect request, single-cycle pulse.
- branch_target  in  ADDR_WIDTH  redirect address.
- fetch_count  out  CNT_WIDTH  instructions delivered to decode.

## Operation
- States: IDLE, REQ, HOLD, REDIRECT.
- IDLE:
  - branch_req → REDIRECT.
  - run → REQ.
- REQ:
  - imem_req=1; imem_addr=pc_addr, held stable until ack.
  - A request is never withdrawn before imem_ack.
  - On imem_ack with no branch pending and no branch_req this cycle:
    - ir ← imem_data; ir_valid ← 1.
    - inc_pc=1 combinationally in the ack cycle, so the PC increments on the same edge.
    - → HOLD.
- HOLD:
  - ir_valid=1, ir stable.
  - ir_ready without branch_req:
    - fetch_count increments; ir_valid ← 0.
    - → REQ if run, else IDLE.
  - ir_ready with branch_req: fetch_count increments, then → REDIRECT.
  - branch_req without ir_ready: ir_valid ← 0 (flush, no count) → REDIRECT.
- REDIRECT:
  - load_pc=1 for exactly one cycle; jump_target=saved target.
  - Then → REQ if run, else IDLE.
- Branch capture:
  - branch_req in any state stores branch_target in target_q and sets pend.
  - A newer branch_req overwrites target_q, including in REDIRECT, which then repeats for one more cycle.
  - In REQ, branch_req or pend with ack: discard data, no inc_pc, → REDIRECT.
  - Without ack: stay in REQ, keep pend.
  - pend clears on leaving REDIRECT.
- Priority: load_pc and inc_pc are never high together.
- fetch_count wraps from 2^CNT_WIDTH−1 to 0.
- run deasserted in REQ does not abort the read. The fetch completes, and HOLD then goes to IDLE after consumption.

## Timing
- Reset (asynchronous, active-low): state=IDLE, ir=0, ir_valid=0, fetch_count=0, target_q=0, pend=0.
  - Outputs during reset: imem_req=0, inc_pc=0, load_pc=0, jump_target=0, imem_addr=pc_addr.
- Reset asserted mid-read drops imem_req immediately. A late ack after reset is ignored in IDLE.
- Latency from run rising to imem_req: 1 cycle.
- ack → ir_valid: registered, visible the next cycle.
- Steady-state throughput with zero-wait memory (ack in the first REQ cycle) and ir_ready tied high: 1 instruction per 2 cycles.
- Branch → load_pc: load_pc follows branch_req by 1 cycle (REDIRECT). It is delayed until ack if a read is outstanding.
- Branch → first fetch of target: imem_addr=target appears 1 cycle after load_pc.
- inc_pc and load_pc are combinational, single-cycle pulses.

## Structure
- Shared constants header holds:
  - state encodings FETCH_IDLE/REQ/HOLD/REDIRECT (2 bits);
  - default ADDR_WIDTH and INSTR_WIDTH, shared with pc.
- Single module with no sub-modules. The PC stays external; the bench instantiates pc beside instr_fetch.

## Test plan
- Reset then run=1, memory acks in 1 cycle with data=addr+0x100, ir_ready=1:
  - ir sequence 0x0100, 0x0101, 0x0102;
  - inc_pc pulses coincide with acks;
  - fetch_count=3.
- Stall: ir_ready=0 for 5 cycles in HOLD:
  - ir and ir_valid stable;
  - imem_req=0;
  - no inc_pc;
  - fetch_count unchanged.
- Branch in HOLD, target 0x0040:
  - ir_valid drops, no count;
  - load_pc pulses with jump_target=0x0040;
  - next imem_addr=0x0040.
- Branch during outstanding read (ack delayed 3 cycles), target 0x0080:
  - imem_req held until ack;
  - data discarded, no inc_pc;
  - load_pc pulses with jump_target=0x0080 the cycle after ack.
- Two branches (0x10, then 0x20) on consecutive cycles:
  - jump_target=0x20 on the final load_pc;
  - fetch resumes at 0x20.
- reset asserted during REQ, with ack arriving 1 cycle after reset releases: all outputs return to reset values, and no ir update or inc_pc occurs.
